// File: rtl/rng_share_ctrl.sv
// Round-robin distributor for a single 16-bit xor-fold random generator.
// Each grant delivers one word, and the generator advances only on delivery.
module rng_share_ctrl #(
  parameter int          NUM_REQ    = 4,
  parameter int          IDW        = 2,
  parameter int          WARMUP     = 16,
  parameter logic [15:0] RESET_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        seed,
  input  logic               seed_load,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               out_valid,
  output logic [15:0]        out_data,
  output logic [IDW-1:0]     out_id,
  output logic               busy
);

  typedef enum logic {
    WARM,
    READY
  } fsm_e;

  localparam fsm_e       INIT_ST  = (WARMUP == 0) ? READY : WARM;
  localparam logic [7:0] WARM_CNT = 8'(WARMUP);

  function automatic logic [15:0] step16(
    input logic [15:0] s
  );
    logic [15:0] n;
    n     = '0;
    n[15] = s[15] ^ s[1];
    n[14] = s[14] ^ s[0];
    for (int i = 13; i >= 0; i--) begin
      n[i] = s[i] ^ n[i+2];
    end
    return n;
  endfunction

  fsm_e               fsm_q, fsm_d;
  logic [15:0]        state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [15:0]        data_q, data_d;
  logic [IDW-1:0]     id_q, id_d;

  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     win_nxt;
  int                 j;

  // Last winner is masked so a lone requester gets every other cycle.
  always_comb begin
    elig  = req & ~gnt_q;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      if (!found && elig[j]) begin
        found = 1'b1;
        win   = IDW'(j);
      end
    end
    win_nxt = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    data_d  = data_q;
    id_d    = id_q;
    if (seed_load) begin
      state_d = (seed == 16'h0000) ? RESET_SEED : seed;
      cnt_d   = WARM_CNT;
      fsm_d   = INIT_ST;
    end else begin
      unique case (fsm_q)
        WARM: begin
          state_d = step16(state_q);
          cnt_d   = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            fsm_d = READY;
          end
        end
        READY: begin
          if (found) begin
            gnt_d   = NUM_REQ'(1) << win;
            data_d  = state_q;
            id_d    = win;
            state_d = step16(state_q);
            ptr_d   = win_nxt;
          end
        end
        default: fsm_d = INIT_ST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= INIT_ST;
      state_q <= RESET_SEED;
      cnt_q   <= WARM_CNT;
      ptr_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = |gnt_q;
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign busy      = (fsm_q == WARM);

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Scoreboard bench for rng_share_ctrl: one instance without warm-up,
// one with a 16-step warm-up, sharing clock and reset.
module tb_rng_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] seed0, seed1;
  logic        ld0, ld1;
  logic [3:0]  req0, req1;
  logic [3:0]  g0, g1;
  logic        v0, v1;
  logic [15:0] d0, d1;
  logic [1:0]  i0, i1;
  logic        b0, b1;

  rng_share_ctrl #(
    .NUM_REQ(4), .IDW(2), .WARMUP(0), .RESET_SEED(16'hACE1)
  ) u_w0 (
    .clk(clk), .rst_n(rst_n), .seed(seed0), .seed_load(ld0),
    .req(req0), .gnt(g0), .out_valid(v0), .out_data(d0),
    .out_id(i0), .busy(b0)
  );

  rng_share_ctrl #(
    .NUM_REQ(4), .IDW(2), .WARMUP(16), .RESET_SEED(16'hACE1)
  ) u_w16 (
    .clk(clk), .rst_n(rst_n), .seed(seed1), .seed_load(ld1),
    .req(req1), .gnt(g1), .out_valid(v1), .out_data(d1),
    .out_id(i1), .busy(b1)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  g;
    logic [15:0] d;
    logic [1:0]  id;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   c;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] stepn(input logic [15:0] s, input int n);
    logic [15:0] x, y;
    x = s;
    for (int k = 0; k < n; k++) begin
      y[15] = x[15] ^ x[1];
      y[14] = x[14] ^ x[0];
      for (int i = 13; i >= 0; i--) y[i] = x[i] ^ y[i+2];
      x = y;
    end
    return x;
  endfunction

  task automatic cmp(input string nm, input exp_t e, input logic [3:0] g,
                     input logic [15:0] d, input logic [1:0] id);
    checks++;
    if (e.cyc != 32'(cyc) || e.g != g || e.d != d || e.id != id) begin
      failures++;
      $display("FAIL %s got cyc=%0d gnt=%b data=%h id=%0d exp cyc=%0d gnt=%b data=%h id=%0d",
               nm, cyc, g, d, id, e.cyc, e.g, e.d, e.id);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (v0 !== |g0 || v1 !== |g1) begin
        failures++;
        $display("FAIL valid_vs_gnt v0=%b g0=%b v1=%b g1=%b", v0, g0, v1, g1);
      end
    end
    if (v0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w0_unexpected cyc=%0d gnt=%b data=%h id=%0d", cyc, g0, d0, i0);
      end else begin
        e0 = q0.pop_front();
        cmp("w0_word", e0, g0, d0, i0);
      end
    end
    if (v1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w16_unexpected cyc=%0d gnt=%b data=%h id=%0d", cyc, g1, d1, i1);
      end else begin
        e1 = q1.pop_front();
        cmp("w16_word", e1, g1, d1, i1);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    seed0 = '0; seed1 = '0;
    ld0 = 1'b0; ld1 = 1'b0;
    req0 = '0; req1 = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(g1), 32'h0);
    chk("rst_valid", 32'(v1), 32'h0);
    chk("rst_data", 32'(d1), 32'h0);
    chk("rst_id", 32'(i1), 32'h0);
    chk("rst_busy16", 32'(b1), 32'h1);
    chk("rst_busy0", 32'(b0), 32'h0);

    // warm-up after reset, request held from the first cycle
    rst_n = 1'b1;
    req1  = 4'b0100;
    c = cyc;
    q1.push_back('{32'(c + 17), 4'b0100, stepn(16'hACE1, 16), 2'd2});
    for (int k = 0; k < 16; k++) begin
      chk("warm_busy", 32'(b1), 32'h1);
      chk("warm_gnt", 32'(g1), 32'h0);
      tick();
    end
    chk("ready_busy", 32'(b1), 32'h0);
    tick();
    req1 = '0;
    tick();

    // single requester served every other cycle
    ld0 = 1'b1; seed0 = 16'h0001;
    tick();
    ld0 = 1'b0; req0 = 4'b0001;
    c = cyc;
    q0.push_back('{32'(c + 1), 4'b0001, 16'h0001, 2'd0});
    q0.push_back('{32'(c + 3), 4'b0001, 16'h5554, 2'd0});
    repeat (4) tick();
    req0 = '0;
    repeat (2) tick();

    // zero-seed guard
    ld0 = 1'b1; seed0 = 16'h0000;
    tick();
    ld0 = 1'b0; req0 = 4'b0001;
    c = cyc;
    q0.push_back('{32'(c + 1), 4'b0001, 16'hACE1, 2'd0});
    tick();
    req0 = '0;
    repeat (2) tick();

    // reseed collides with a pending grant
    req1 = 4'b0010; ld1 = 1'b1; seed1 = 16'h1234;
    c = cyc;
    q1.push_back('{32'(c + 18), 4'b0010, stepn(16'h1234, 16), 2'd1});
    tick();
    ld1 = 1'b0;
    chk("seed_gnt", 32'(g1), 32'h0);
    chk("seed_valid", 32'(v1), 32'h0);
    chk("seed_busy", 32'(b1), 32'h1);
    repeat (17) tick();
    req1 = '0;
    tick();

    // full round-robin sweep
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ld0 = 1'b1; seed0 = 16'h0001;
    tick();
    ld0 = 1'b0; req0 = 4'b1111;
    c = cyc;
    q0.push_back('{32'(c + 1), 4'b0001, 16'h0001, 2'd0});
    q0.push_back('{32'(c + 2), 4'b0010, 16'h5554, 2'd1});
    q0.push_back('{32'(c + 3), 4'b0100, stepn(16'h0001, 2), 2'd2});
    q0.push_back('{32'(c + 4), 4'b1000, stepn(16'h0001, 3), 2'd3});
    q0.push_back('{32'(c + 5), 4'b0001, stepn(16'h0001, 4), 2'd0});
    repeat (5) tick();
    req0 = '0;
    repeat (13) tick();

    // reset in the middle of a burst
    req1 = 4'b1111;
    c = cyc;
    q1.push_back('{32'(c + 1), 4'b0001, stepn(16'hACE1, 16), 2'd0});
    q1.push_back('{32'(c + 2), 4'b0010, stepn(16'hACE1, 17), 2'd1});
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_gnt", 32'(g1), 32'h0);
    chk("mid_rst_valid", 32'(v1), 32'h0);
    chk("mid_rst_data", 32'(d1), 32'h0);
    chk("mid_rst_id", 32'(i1), 32'h0);
    chk("mid_rst_busy", 32'(b1), 32'h1);
    rst_n = 1'b1;
    c = cyc;
    q1.push_back('{32'(c + 17), 4'b0001, stepn(16'hACE1, 16), 2'd0});
    q1.push_back('{32'(c + 18), 4'b0010, stepn(16'hACE1, 17), 2'd1});
    repeat (18) tick();
    req1 = '0;
    repeat (3) tick();

    chk("w0_pending", 32'(q0.size()), 32'h0);
    chk("w16_pending", 32'(q1.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rng_share_ctrl.md
Name: rng_share_ctrl

Overview:
- Owns one 16-bit xor-fold random generator state and shares it round-robin among NUM_REQ requesters.
- Each grant delivers exactly one word, and the generator advances only on delivery, so no two requesters ever receive the same word.
- Handles seeding, including a zero-seed guard and a configurable warm-up run before words are served.
- Sits between the 2D consumers (sprite and tile randomisers) and the random source.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, 2, width of out_id; must satisfy 2^IDW >= NUM_REQ.
- WARMUP, 16, generator steps run after reset or reseed before the first grant (0..255).
- RESET_SEED, 16'hACE1, state loaded at reset and substituted for a zero seed.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: synchronous active-low reset.
- seed, input, 16: seed value, sampled when seed_load=1.
- seed_load, input, 1: single-cycle reseed command.
- req, input, NUM_REQ: level request, one bit per requester.
- gnt, output, NUM_REQ: registered one-hot grant, 1 cycle per word.
- out_valid, output, 1: word valid; high exactly when gnt != 0.
- out_data, output, 16: delivered random word.
- out_id, output, IDW: index of the granted requester.
- busy, output, 1: high while in WARM (seeding or warm-up).

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low; all state updates on the rising edge of clk.
- Step function (s -> n):
  - n15 = s15 ^ s1
  - n14 = s14 ^ s0
  - for i = 13 down to 0: n[i] = s[i] ^ n[i+2]
- Reset (rst_n=0 at an edge):
  - state = RESET_SEED; warm counter = WARMUP.
  - gnt = 0, out_valid = 0, out_data = 0, out_id = 0.
  - RR pointer = 0 (requester 0 has highest priority first).
  - FSM = WARM, or READY if WARMUP = 0.
  - busy follows the FSM (1 in WARM).
- FSM states: WARM, READY.
- WARM:
  - busy = 1; gnt = 0; requests are ignored (not queued).
  - Each cycle: state = step(state), counter decrements.
  - When the counter reaches 0, the next state is READY.
  - WARM therefore lasts exactly WARMUP cycles, and the first word served equals step^WARMUP(seed).
- READY, arbitration each cycle:
  - Eligible = req & ~gnt. The requester granted this cycle is masked from the next arbitration, so a continuous single requester is served every other cycle.
  - Winner = first eligible index searching upward from the RR pointer, wrapping modulo NUM_REQ.
  - If there is a winner, at the next edge: gnt = onehot(winner), out_valid = 1, out_data = current state, out_id = winner, state = step(state), pointer = winner+1 mod NUM_REQ.
  - Otherwise gnt = 0 and out_valid = 0; state and pointer hold.
  - out_data holds its last value when out_valid = 0.
- Latency: a request is sampled at edge k and gnt/out_valid are visible after edge k (1 cycle). Different requesters can be served back-to-back, one word per cycle.
- seed_load (any state) has priority over arbitration and warm-up:
  - state = (seed == 0) ? RESET_SEED : seed.
  - counter = WARMUP; FSM = WARM (or READY if WARMUP = 0).
  - gnt = 0 and out_valid = 0 at the next edge; the word that would have been granted is not delivered; pointer unchanged.
  - seed_load while already in WARM restarts the warm-up.
- Reset has priority over seed_load.
- A requester that drops req before its grant is simply not served; gnt never asserts for an index with req = 0 at the sampling edge.
- An all-zero state is unreachable: only the zero-seed path could create it, and it is blocked by the guard.

Test Plan:
- WARMUP=0, seed_load with seed=16'h0001, then req=4'b0001 held -> words 16'h0001 then 16'h5554, out_id=0, gnt every other cycle.
- WARMUP=0, seed_load with seed=16'h0000, then req0 -> first out_data=16'hACE1 (zero-seed guard).
- WARMUP=0, seed 16'h0001, req=4'b1111 held -> gnt 0001, 0010, 0100, 1000, 0001 on consecutive cycles, out_id 0,1,2,3,0; first two words 16'h0001, 16'h5554; all delivered words pairwise consistent with the step chain.
- WARMUP=16 after reset, req=4'b0100 from the first cycle -> busy=1 for 16 cycles, no gnt; first gnt at cycle 17 with out_data = step^16(16'hACE1) per the reference model.
- seed_load asserted in the same cycle a grant would occur (req=4'b0010, READY) -> no gnt/out_valid next cycle; after the warm-up, the first word is derived from the new seed.
- rst_n=0 mid-burst (req=4'b1111) -> next edge gnt=0, out_valid=0, out_data=0, busy=1, pointer back to 0; after the warm-up the first grant goes to requester 0.
